hwpe_axi_sink_writer: RTL and testbench
=======================================

HWPE_AXI_SINK_WRITER -- requirements
Module: hwpe_axi_sink_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, TCDM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, stream and TCDM data width.
REQ-003 SHALL have parameter BE_WIDTH, default DATA_WIDTH/8, byte-enable and TSTRB width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of beat-buffer entries (power of two, at least 2).
REQ-005 SHALL have parameter WORD_STRIDE, default 4, byte increment between consecutive stores.
REQ-006 SHALL have the following ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  start request; sampled only in IDLE.
- ready_start_o  in/out: out  1  high in IDLE.
- cfg_base_addr_i  in  ADDR_WIDTH  first store address.
- cfg_n_words_i  in  16  beats to store per job.
- done_o  out  1  one-cycle job-complete pulse.
- tlast_err_o  out  1  sticky TLAST-mismatch flag.
- TVALID_i  in  1  stream beat valid.
- TREADY_o  out  1  stream ready.
- TDATA_i  in  DATA_WIDTH  beat data.
- TSTRB_i  in  BE_WIDTH  beat byte strobes.
- TLAST_i  in  1  last beat of the job.
- tcdm_req_o  out  1  TCDM request.
- tcdm_gnt_i  in  1  TCDM grant.
- tcdm_add_o  out  ADDR_WIDTH  store address.
- tcdm_type_o  out  1  0 = store, 1 = load.
- tcdm_be_o  out  BE_WIDTH  store byte enables.
- tcdm_data_o  out  DATA_WIDTH  store data.
- tcdm_r_valid_i  in  1  store response; ignored.

Function
REQ-007 FSM SHALL have the states IDLE, SINK and DONE.
REQ-008 IDLE SHALL transition on start_i=1:
- capture cfg_base_addr_i into the address register and cfg_n_words_i into the word limit;
- clear both counters (accepted, stored) and tlast_err_o;
- go to DONE if the limit is 0, else go to SINK.
REQ-009 TREADY_o SHALL be 1 only when all of these hold: state is SINK, FIFO is not full, accepted count is below the limit.
REQ-010 A beat SHALL be accepted when TVALID_i and TREADY_o are both 1; {TDATA_i, TSTRB_i} is pushed to the FIFO and the accepted count is incremented.
REQ-011 tcdm_req_o SHALL be 1 whenever the state is SINK and the FIFO is not empty; it is not gated by TVALID_i.
REQ-012 While tcdm_req_o=1, the module SHALL drive:
- tcdm_add_o = the address register;
- tcdm_data_o and tcdm_be_o = the FIFO head;
- tcdm_type_o = 0.
REQ-013 When tcdm_req_o=0, tcdm_add_o, tcdm_data_o and tcdm_be_o SHALL be 0, and tcdm_type_o SHALL be 1.
REQ-014 On tcdm_req_o and tcdm_gnt_i both 1, the module SHALL:
- pop the FIFO head;
- add WORD_STRIDE to the address register, wrapping modulo 2^ADDR_WIDTH;
- increment the stored count.
REQ-015 Request fields SHALL hold stable while tcdm_req_o=1 and tcdm_gnt_i=0.
REQ-016 Minimum latency SHALL be one cycle: a beat accepted in cycle N is first requested in cycle N+1.
REQ-017 A simultaneous push and pop SHALL be legal, including at full, and SHALL leave the occupancy unchanged; TREADY_o still depends only on the registered full flag.
REQ-018 SINK SHALL go to DONE in the cycle after the grant that makes the stored count equal the limit.
REQ-019 DONE SHALL assert done_o for exactly one cycle and then return to IDLE.
REQ-020 tlast_err_o SHALL be set when either of these is accepted:
- a beat with TLAST_i=1 whose index is not limit-1;
- the beat at index limit-1 with TLAST_i=0.
REQ-021 tlast_err_o SHALL otherwise hold until the next start; the job continues regardless of the flag.
REQ-022 start_i outside IDLE SHALL be ignored.
REQ-023 Beats presented after the limit is reached SHALL remain unaccepted (TREADY_o=0).

Reset
REQ-024 On rst_n=0 the module SHALL asynchronously:
- go to IDLE;
- flush the FIFO;
- clear the counters and the address register;
- drive every output to 0 except ready_start_o=1 and tcdm_type_o=1.
REQ-025 A reset during SINK SHALL abandon the job with no done_o, and subsequent operation SHALL be as after power-up.

Structure
REQ-026 The FSM state enum and the tcdm_type encodings (STORE=0, LOAD=1) SHALL live in the shared HWPE AXI package.
REQ-027 The beat buffer SHALL be one sub-module, hwpe_axi_sink_beat_fifo (parameters DATA_WIDTH+BE_WIDTH, FIFO_DEPTH), with registered full and empty flags.

Verification
REQ-028 Base 0x1000, 4 words, continuous TVALID, gnt=1: stores to 0x1000, 0x1004, 0x1008 and 0x100C in order with matching data; done_o is one pulse; tlast_err_o=0.
REQ-029 gnt held 0 for 10 cycles mid-job: TREADY_o drops after FIFO_DEPTH beats buffered, request fields are stable, and no beat is lost or duplicated.
REQ-030 n_words=0: start leads to done_o two cycles later; no tcdm_req_o and no TREADY_o.
REQ-031 Base 0xFFFFFFF8, 4 words: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-032 TLAST on beat 2 of 4: tlast_err_o=1, all 4 beats are still stored, done_o is pulsed, and tlast_err_o is cleared by the next start.
REQ-033 rst_n pulsed after 2 of 8 stores: outputs return to reset values immediately, and a new job with base 0x2000 behaves as REQ-028.

Source files
------------

// File: rtl/hwpe_axi_sink_writer_pkg.sv
// Shared HWPE AXI definitions: sink FSM state encoding and
// TCDM transaction type encodings.
package hwpe_axi_sink_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SINK = 2'd1,
        ST_DONE = 2'd2
    } sink_state_e;

    localparam logic TCDM_STORE = 1'b0;
    localparam logic TCDM_LOAD  = 1'b1;

endpackage

// File: rtl/hwpe_axi_sink_beat_fifo.sv
// Beat buffer between the stream side and the TCDM side.
// Ports: push_i/wdata_i write, pop_i/rdata_o read head, full_o/empty_o flags.
module hwpe_axi_sink_beat_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [PW:0]      cnt_q;
    logic [PW:0]      cnt_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // A push at full is taken only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && (!full_q || do_pop);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wptr_q <= wptr_q + PW'(1);
            if (do_pop)  rptr_q <= rptr_q + PW'(1);
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_FULL);
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/hwpe_axi_sink_writer.sv
// Stream-to-TCDM sink: buffers AXI-stream beats and stores them to
// consecutive TCDM addresses; start/ready/done job handshake, TLAST check.
module hwpe_axi_sink_writer
    import hwpe_axi_sink_writer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BE_WIDTH    = DATA_WIDTH/8,
    parameter int FIFO_DEPTH  = 4,
    parameter int WORD_STRIDE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic                  ready_start_o,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_i,
    input  logic [15:0]           cfg_n_words_i,
    output logic                  done_o,
    output logic                  tlast_err_o,
    input  logic                  TVALID_i,
    output logic                  TREADY_o,
    input  logic [DATA_WIDTH-1:0] TDATA_i,
    input  logic [BE_WIDTH-1:0]   TSTRB_i,
    input  logic                  TLAST_i,
    output logic                  tcdm_req_o,
    input  logic                  tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0] tcdm_add_o,
    output logic                  tcdm_type_o,
    output logic [BE_WIDTH-1:0]   tcdm_be_o,
    output logic [DATA_WIDTH-1:0] tcdm_data_o,
    input  logic                  tcdm_r_valid_i
);

    localparam int FW = DATA_WIDTH + BE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(WORD_STRIDE);

    sink_state_e           state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           limit_q;
    logic [15:0]           acc_q;
    logic [15:0]           stored_q;
    logic                  err_q;
    logic                  done_q;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FW-1:0]         fifo_head;
    logic                  push;
    logic                  pop;
    logic                  req;
    logic                  is_last_idx;
    logic                  unused_rvalid;

    // Store responses carry nothing this block needs.
    assign unused_rvalid = tcdm_r_valid_i;

    assign TREADY_o    = (state_q == ST_SINK) && !fifo_full
                         && (acc_q < limit_q);
    assign push        = TVALID_i && TREADY_o;
    assign req         = (state_q == ST_SINK) && !fifo_empty;
    assign pop         = req && tcdm_gnt_i;
    assign is_last_idx = (acc_q == limit_q - 16'd1);

    hwpe_axi_sink_beat_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) i_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({TDATA_i, TSTRB_i}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            limit_q  <= '0;
            acc_q    <= '0;
            stored_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        addr_q   <= cfg_base_addr_i;
                        limit_q  <= cfg_n_words_i;
                        acc_q    <= '0;
                        stored_q <= '0;
                        err_q    <= 1'b0;
                        state_q  <= (cfg_n_words_i == '0) ? ST_DONE : ST_SINK;
                    end
                end
                ST_SINK: begin
                    if (push) begin
                        acc_q <= acc_q + 16'd1;
                        if (TLAST_i != is_last_idx) err_q <= 1'b1;
                    end
                    if (pop) begin
                        addr_q   <= addr_q + STRIDE;
                        stored_q <= stored_q + 16'd1;
                        if (stored_q + 16'd1 == limit_q) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready_start_o = (state_q == ST_IDLE);
    assign done_o        = done_q;
    assign tlast_err_o   = err_q;
    assign tcdm_req_o    = req;
    assign tcdm_type_o   = req ? TCDM_STORE : TCDM_LOAD;
    assign tcdm_add_o    = req ? addr_q : '0;
    assign tcdm_data_o   = req ? fifo_head[FW-1:BE_WIDTH] : '0;
    assign tcdm_be_o     = req ? fifo_head[BE_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_hwpe_axi_sink_writer.sv
// Directed bench for hwpe_axi_sink_writer: basic job, grant stall,
// zero-length job, address wrap, TLAST mismatch, reset mid-job.
module tb_hwpe_axi_sink_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic        ready_start_o;
    logic [31:0] cfg_base_addr_i;
    logic [15:0] cfg_n_words_i;
    logic        done_o;
    logic        tlast_err_o;
    logic        TVALID_i;
    logic        TREADY_o;
    logic [31:0] TDATA_i;
    logic [3:0]  TSTRB_i;
    logic        TLAST_i;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i;
    logic [31:0] tcdm_add_o;
    logic        tcdm_type_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_data_o;
    logic        tcdm_r_valid_i;

    always #5 clk = ~clk;

    hwpe_axi_sink_writer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .ready_start_o   (ready_start_o),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_n_words_i   (cfg_n_words_i),
        .done_o          (done_o),
        .tlast_err_o     (tlast_err_o),
        .TVALID_i        (TVALID_i),
        .TREADY_o        (TREADY_o),
        .TDATA_i         (TDATA_i),
        .TSTRB_i         (TSTRB_i),
        .TLAST_i         (TLAST_i),
        .tcdm_req_o      (tcdm_req_o),
        .tcdm_gnt_i      (tcdm_gnt_i),
        .tcdm_add_o      (tcdm_add_o),
        .tcdm_type_o     (tcdm_type_o),
        .tcdm_be_o       (tcdm_be_o),
        .tcdm_data_o     (tcdm_data_o),
        .tcdm_r_valid_i  (tcdm_r_valid_i)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] st_addr[$];
    logic [31:0] st_data[$];
    logic [3:0]  st_be[$];
    int          accepted;
    int          done_cnt;
    int          hold_viol;
    int          idle_viol;
    int          first_acc;
    int          first_req;
    int          stall_occ;
    logic        stall_tready;
    logic        prev_hold;
    logic [31:0] p_add;
    logic [31:0] p_data;
    logic [3:0]  p_be;
    logic [31:0] seed;

    task automatic sample(input int cyc, input int stall_end);
        if (tcdm_req_o) begin
            if (first_req < 0) first_req = cyc;
            if (prev_hold && (tcdm_add_o !== p_add || tcdm_data_o !== p_data
                              || tcdm_be_o !== p_be))
                hold_viol++;
            if (tcdm_type_o !== 1'b0) idle_viol++;
        end else if (tcdm_type_o !== 1'b1 || tcdm_add_o !== 32'h0
                     || tcdm_data_o !== 32'h0 || tcdm_be_o !== 4'h0) begin
            idle_viol++;
        end
        prev_hold = tcdm_req_o && !tcdm_gnt_i;
        p_add  = tcdm_add_o;
        p_data = tcdm_data_o;
        p_be   = tcdm_be_o;
        if (tcdm_req_o && tcdm_gnt_i) begin
            st_addr.push_back(tcdm_add_o);
            st_data.push_back(tcdm_data_o);
            st_be.push_back(tcdm_be_o);
        end
        if (TVALID_i && TREADY_o) begin
            if (first_acc < 0) first_acc = cyc;
            accepted++;
        end
        if (done_o) done_cnt++;
        if (cyc == stall_end) begin
            stall_occ    = accepted - st_addr.size();
            stall_tready = TREADY_o;
        end
    endtask

    // Runs one job with continuous TVALID; beat k carries seed+k.
    task automatic run_job(input logic [31:0] base, input logic [15:0] n,
                           input int last_idx, input int stall_at,
                           input int stall_len);
        int cyc;
        st_addr.delete();
        st_data.delete();
        st_be.delete();
        accepted = 0; done_cnt = 0; hold_viol = 0; idle_viol = 0;
        first_acc = -1; first_req = -1; stall_occ = -1;
        stall_tready = 1'b1; prev_hold = 1'b0; cyc = 0;
        cfg_base_addr_i = base;
        cfg_n_words_i   = n;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (done_cnt == 0 && cyc < 400) begin
            TVALID_i   = 1'b1;
            TDATA_i    = seed + 32'(accepted);
            TSTRB_i    = 4'hF ^ 4'(accepted);
            TLAST_i    = (accepted == last_idx);
            tcdm_gnt_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
            @(negedge clk);
            sample(cyc, stall_at + stall_len - 1);
            @(posedge clk); #1;
            cyc++;
        end
        tcdm_gnt_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            TDATA_i = seed + 32'(accepted);
            @(negedge clk);
            sample(cyc, -5);
            @(posedge clk); #1;
            cyc++;
        end
        TVALID_i = 1'b0;
        TLAST_i  = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (ready_start_o !== 1'b1 || tcdm_type_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_hi: ready_start=%b type=%b want 1 1",
                     ready_start_o, tcdm_type_o);
        end
        total++;
        if ({done_o, tlast_err_o, TREADY_o, tcdm_req_o} !== 4'b0
            || tcdm_add_o !== 32'h0 || tcdm_data_o !== 32'h0 || tcdm_be_o !== 4'h0) begin
            bad++;
            $display("FAIL reset_lo: done=%b err=%b tready=%b req=%b add=%h want all 0",
                     done_o, tlast_err_o, TREADY_o, tcdm_req_o, tcdm_add_o);
        end
    endtask

    task automatic test_basic(input logic [31:0] base, input string tag);
        seed = 32'hA5A5_0000 ^ base;
        run_job(base, 16'd4, 3, -10, 0);
        total++;
        if (done_cnt !== 1) begin
            bad++;
            $display("FAIL %s_done: pulses=%0d want 1", tag, done_cnt);
        end
        total++;
        if (accepted !== 4 || st_addr.size() !== 4) begin
            bad++;
            $display("FAIL %s_count: accepted=%0d stored=%0d want 4 4",
                     tag, accepted, st_addr.size());
        end
        for (int i = 0; i < st_addr.size() && i < 4; i++) begin
            total++;
            if (st_addr[i] !== base + 32'(4*i) || st_data[i] !== seed + 32'(i)
                || st_be[i] !== (4'hF ^ 4'(i))) begin
                bad++;
                $display("FAIL %s_store%0d: add=%h data=%h be=%h want %h %h %h",
                         tag, i, st_addr[i], st_data[i], st_be[i],
                         base + 32'(4*i), seed + 32'(i), 4'hF ^ 4'(i));
            end
        end
        total++;
        if (tlast_err_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_err: tlast_err=%b want 0", tag, tlast_err_o);
        end
        total++;
        if (first_req - first_acc !== 1 || idle_viol !== 0) begin
            bad++;
            $display("FAIL %s_latency: first_req-first_acc=%0d idle_viol=%0d want 1 0",
                     tag, first_req - first_acc, idle_viol);
        end
    endtask

    task automatic test_stall();
        seed = 32'h5000_0000;
        run_job(32'h4000, 16'd10, 9, 2, 10);
        total++;
        if (stall_tready !== 1'b0 || stall_occ !== 4) begin
            bad++;
            $display("FAIL stall_full: tready=%b buffered=%0d want 0 4",
                     stall_tready, stall_occ);
        end
        total++;
        if (hold_viol !== 0) begin
            bad++;
            $display("FAIL stall_hold: changes=%0d want 0", hold_viol);
        end
        total++;
        if (st_addr.size() !== 10 || accepted !== 10 || done_cnt !== 1) begin
            bad++;
            $display("FAIL stall_count: stored=%0d accepted=%0d done=%0d want 10 10 1",
                     st_addr.size(), accepted, done_cnt);
        end
        for (int i = 0; i < st_addr.size() && i < 10; i++) begin
            total++;
            if (st_addr[i] !== 32'h4000 + 32'(4*i) || st_data[i] !== seed + 32'(i)) begin
                bad++;
                $display("FAIL stall_store%0d: add=%h data=%h want %h %h", i,
                         st_addr[i], st_data[i], 32'h4000 + 32'(4*i), seed + 32'(i));
            end
        end
    endtask

    task automatic test_zero();
        int seen_req;
        int seen_rdy;
        logic [3:0] dn;
        seen_req = 0; seen_rdy = 0; dn = 4'h0;
        cfg_base_addr_i = 32'h1234;
        cfg_n_words_i   = 16'd0;
        TVALID_i = 1'b1;
        start_i  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dn[c] = done_o;
            if (tcdm_req_o) seen_req++;
            if (TREADY_o) seen_rdy++;
            @(posedge clk); #1;
            start_i = 1'b0;
        end
        TVALID_i = 1'b0;
        total++;
        if (dn !== 4'b0100) begin
            bad++;
            $display("FAIL zero_done: done by cycle=%b want 0100", dn);
        end
        total++;
        if (seen_req !== 0 || seen_rdy !== 0) begin
            bad++;
            $display("FAIL zero_quiet: req=%0d tready=%0d want 0 0", seen_req, seen_rdy);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
        seed = 32'h0BAD_0000;
        run_job(32'hFFFF_FFF8, 16'd4, 3, -10, 0);
        total++;
        if (st_addr.size() !== 4) begin
            bad++;
            $display("FAIL wrap_count: stored=%0d want 4", st_addr.size());
        end
        for (int i = 0; i < st_addr.size() && i < 4; i++) begin
            total++;
            if (st_addr[i] !== exp_a[i]) begin
                bad++;
                $display("FAIL wrap_add%0d: add=%h want %h", i, st_addr[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_tlast();
        seed = 32'h7700_0000;
        run_job(32'h6000, 16'd4, 1, -10, 0);
        total++;
        if (tlast_err_o !== 1'b1) begin
            bad++;
            $display("FAIL tlast_set: tlast_err=%b want 1", tlast_err_o);
        end
        total++;
        if (st_addr.size() !== 4 || done_cnt !== 1) begin
            bad++;
            $display("FAIL tlast_job: stored=%0d done=%0d want 4 1",
                     st_addr.size(), done_cnt);
        end
        cfg_n_words_i = 16'd0;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        total++;
        if (tlast_err_o !== 1'b0) begin
            bad++;
            $display("FAIL tlast_clear: tlast_err=%b want 0", tlast_err_o);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int stores;
        int cyc;
        int acc;
        int dn;
        stores = 0; cyc = 0; acc = 0; dn = 0;
        cfg_base_addr_i = 32'h3000;
        cfg_n_words_i   = 16'd8;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        tcdm_gnt_i = 1'b1;
        while (stores < 2 && cyc < 50) begin
            TVALID_i = 1'b1;
            TDATA_i  = 32'hD000 + 32'(acc);
            TSTRB_i  = 4'hF;
            TLAST_i  = (acc == 0);
            @(negedge clk);
            if (tcdm_req_o && tcdm_gnt_i) stores++;
            if (TVALID_i && TREADY_o) acc++;
            if (stores < 2) begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        total++;
        if (stores !== 2 || tlast_err_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_pre: stores=%0d tlast_err=%b want 2 1",
                     stores, tlast_err_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ready_start_o !== 1'b1 || tcdm_type_o !== 1'b1
            || {done_o, tlast_err_o, TREADY_o, tcdm_req_o} !== 4'b0
            || tcdm_add_o !== 32'h0 || tcdm_data_o !== 32'h0 || tcdm_be_o !== 4'h0) begin
            bad++;
            $display("FAIL rstmid_out: rdy=%b type=%b done=%b err=%b tready=%b req=%b add=%h",
                     ready_start_o, tcdm_type_o, done_o, tlast_err_o,
                     TREADY_o, tcdm_req_o, tcdm_add_o);
        end
        TVALID_i = 1'b0;
        TLAST_i  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_o || tcdm_req_o) dn++;
            @(posedge clk); #1;
        end
        total++;
        if (dn !== 0 || ready_start_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_quiet: done/req cycles=%0d rdy=%b want 0 1",
                     dn, ready_start_o);
        end
        test_basic(32'h2000, "after_rst");
    endtask

    initial begin
        rst_n           = 1'b0;
        start_i         = 1'b0;
        cfg_base_addr_i = 32'h0;
        cfg_n_words_i   = 16'd0;
        TVALID_i        = 1'b0;
        TDATA_i         = 32'h0;
        TSTRB_i         = 4'h0;
        TLAST_i         = 1'b0;
        tcdm_gnt_i      = 1'b1;
        tcdm_r_valid_i  = 1'b0;
        seed            = 32'h0;
        test_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic(32'h1000, "basic");
        test_stall();
        test_zero();
        test_wrap();
        test_tlast();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
